// File: rtl/posit_construction.sv
// posit_construction: two-stage pipelined posit encoder (decoded fields -> N-bit posit) with valid/ready on both sides.
// Build option: define POSIT_CONSTRUCT_RNE_EN for round-to-nearest-even; the default build truncates the magnitude.
module posit_construction #(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int RS = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               Sign,
  input  logic signed [RS:0] k,
  input  logic [ES-1:0]      Exponent,
  input  logic [N-1:0]       Mantissa,
  input  logic               inf,
  input  logic               zero,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_posit
);

  localparam int EW = 2 * N;

`ifdef POSIT_CONSTRUCT_RNE_EN
  localparam bit RNE_EN = 1'b1;
`else
  localparam bit RNE_EN = 1'b0;
`endif

  // Regime, exponent and fraction packed left-aligned into a 2N-bit string.
  function automatic logic [EW-1:0] build_ext(input logic signed [RS:0] kin,
                                              input logic [ES-1:0]      e,
                                              input logic [N-2:0]       frac);
    int            kc;
    int            len;
    logic [EW-1:0] regime;
    logic [EW-1:0] tail;
    kc = int'(kin);
    if (kc > N - 2)
      kc = N - 2;
    else if (kc < -(N - 1))
      kc = -(N - 1);
    if (kc >= 0) begin
      regime = ~({EW{1'b1}} >> (kc + 1));
      len    = kc + 2;
    end else begin
      regime = {1'b1, {(EW-1){1'b0}}} >> (-kc);
      len    = 1 - kc;
    end
    tail = {e, frac, {(EW-ES-N+1){1'b0}}};
    return regime | (tail >> len);
  endfunction

  function automatic logic [N-2:0] round_sat(input logic [N-2:0] mag, input logic inc);
    logic [N-1:0] sum;
    logic [N-2:0] res;
    sum = {1'b0, mag} + {{(N-1){1'b0}}, inc};
    res = sum[N-1] ? {(N-1){1'b1}} : sum[N-2:0];
    if (res == '0)
      res = {{(N-2){1'b0}}, 1'b1};
    return res;
  endfunction

  function automatic logic [N-1:0] pack(input logic s, input logic nar, input logic zr,
                                        input logic [N-2:0] mag);
    logic [N-1:0] p;
    p = {1'b0, mag};
    if (s)
      p = -p;
    if (nar)
      p = {1'b1, {(N-1){1'b0}}};
    else if (zr)
      p = '0;
    return p;
  endfunction

  logic          vld_p1_q;
  logic [EW-1:0] ext_p1_q;
  logic [EW-1:0] ext_p1_d;
  logic          sign_p1_q;
  logic          inf_p1_q;
  logic          zero_p1_q;
  logic          vld_p2_q;
  logic [N-1:0]  posit_p2_q;
  logic [N-1:0]  posit_p2_d;
  logic          adv1;
  logic          adv2;
  logic [N-2:0]  mag_p1;
  logic          guard_p1;
  logic          sticky_p1;
  logic          inc_p1;
  logic          unused_hidden;

  assign adv2          = !vld_p2_q | out_ready;
  assign adv1          = !vld_p1_q | adv2;
  assign in_ready      = adv1;
  assign unused_hidden = Mantissa[N-1];

  assign ext_p1_d = build_ext(k, Exponent, Mantissa[N-2:0]);

  // Stage 1: regime construction and field packing
  always_ff @(posedge clk) begin
    if (rst)
      vld_p1_q <= 1'b0;
    else if (adv1)
      vld_p1_q <= in_valid;
    if (adv1 && in_valid) begin
      ext_p1_q  <= ext_p1_d;
      sign_p1_q <= Sign;
      inf_p1_q  <= inf;
      zero_p1_q <= zero;
    end
  end

  assign mag_p1     = ext_p1_q[EW-1 -: N-1];
  assign guard_p1   = ext_p1_q[N];
  assign sticky_p1  = |ext_p1_q[N-1:0];
  assign inc_p1     = RNE_EN & guard_p1 & (sticky_p1 | mag_p1[0]);
  assign posit_p2_d = pack(sign_p1_q, inf_p1_q, zero_p1_q, round_sat(mag_p1, inc_p1));

  // Stage 2: rounding, saturation, sign and specials; output only changes when a result lands
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q   <= 1'b0;
      posit_p2_q <= '0;
    end else if (adv2) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q)
        posit_p2_q <= posit_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign out_posit = posit_p2_q;

endmodule

// File: tb/tb_posit_construction.sv
// Randomized and directed bench for posit_construction against a bit-queue reference encoder.
module tb_posit_construction;
  localparam int N  = 32;
  localparam int ES = 2;
  localparam int RS = 5;

`ifdef POSIT_CONSTRUCT_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               Sign = 1'b0;
  logic signed [RS:0] k = '0;
  logic [ES-1:0]      Exponent = '0;
  logic [N-1:0]       Mantissa = '0;
  logic               inf = 1'b0;
  logic               zero = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [N-1:0]       out_posit;

  typedef struct {
    logic               s;
    logic signed [RS:0] k;
    logic [ES-1:0]      e;
    logic [N-1:0]       m;
    logic               nar;
    logic               zr;
    logic [N-1:0]       want;
    bit                 has_want;
  } item_t;

  typedef struct {
    logic [N-1:0] val;
    int           cyc;
  } exp_t;

  item_t pend[$];
  exp_t  sb[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  bit    lat_chk = 1'b0;

  posit_construction #(.N(N), .ES(ES), .RS(RS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Sign(Sign), .k(k), .Exponent(Exponent), .Mantissa(Mantissa),
    .inf(inf), .zero(zero), .out_valid(out_valid), .out_ready(out_ready),
    .out_posit(out_posit)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: write the posit bit string out one bit at a time, then read the fields back.
  function automatic logic [N-1:0] model(input item_t it);
    bit     q[$];
    int     kk;
    longint m;
    longint maxmag;
    bit     g;
    bit     st;
    logic [N-1:0] r;
    if (it.nar) return {1'b1, {(N-1){1'b0}}};
    if (it.zr) return '0;
    kk = int'(it.k);
    if (kk > N - 2) kk = N - 2;
    if (kk < -(N - 1)) kk = -(N - 1);
    if (kk >= 0) begin
      repeat (kk + 1) q.push_back(1'b1);
      q.push_back(1'b0);
    end else begin
      repeat (-kk) q.push_back(1'b0);
      q.push_back(1'b1);
    end
    for (int i = ES - 1; i >= 0; i--) q.push_back(it.e[i]);
    for (int i = N - 2; i >= 0; i--) q.push_back(it.m[i]);
    m = 0;
    for (int i = 0; i < N - 1; i++) m = m * 2 + (q[i] ? 64'd1 : 64'd0);
    g  = q[N-1];
    st = 1'b0;
    for (int i = N; i < q.size(); i++) st = st | q[i];
    if (RNE && g && (st || m[0])) m++;
    maxmag = (longint'(1) << (N - 1)) - 1;
    if (m > maxmag) m = maxmag;
    if (m == 0) m = 1;
    r = m[N-1:0];
    return it.s ? -r : r;
  endfunction

  task automatic add(input logic s, input int kv, input logic [ES-1:0] e, input logic [N-1:0] m,
                     input logic nar, input logic zr, input logic [N-1:0] want, input bit has_want);
    item_t it;
    it.s = s; it.k = kv[RS:0]; it.e = e; it.m = m; it.nar = nar; it.zr = zr;
    it.want = want; it.has_want = has_want;
    pend.push_back(it);
  endtask

  task automatic add_rand();
    int kv;
    kv = int'($urandom_range(0, 63)) - 32;
    add(1'($urandom_range(0, 1)), kv, ES'($urandom), {1'b1, 31'($urandom)},
        $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, '0, 1'b0);
  endtask

  task automatic drive(input bit vld);
    if (vld && pend.size() > 0) begin
      in_valid = 1'b1;
      Sign = pend[0].s; k = pend[0].k; Exponent = pend[0].e; Mantissa = pend[0].m;
      inf = pend[0].nar; zero = pend[0].zr;
    end else begin
      in_valid = 1'b0;
      Mantissa = $urandom;
      k = RS'($urandom);
    end
  endtask

  task automatic tick();
    exp_t  e;
    item_t it;
    #1;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0)
        check("spurious_out", 32'(out_valid), '0);
      else begin
        e = sb.pop_front();
        check("data", out_posit, e.val);
        if (lat_chk) check("latency", 32'(cyc - e.cyc), 32'd2);
      end
    end
    if (!rst && in_valid && in_ready) begin
      it = pend.pop_front();
      e.val = it.has_want ? it.want : model(it);
      e.cyc = cyc;
      sb.push_back(e);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_stream(input bit rnd, input int maxc);
    int n;
    n = 0;
    while ((pend.size() > 0 || sb.size() > 0) && n < maxc) begin
      drive(rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      n++;
    end
    check("drain_left", 32'(pend.size() + sb.size()), '0);
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), '0);
    check("rst_out_posit", out_posit, '0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Basic encodes streamed back to back, latency checked
    lat_chk = 1'b1;
    add(0, 0, 2'd0, 32'h80000000, 0, 0, 32'h40000000, 1);
    add(0, 0, 2'd1, 32'h80000000, 0, 0, 32'h48000000, 1);
    add(1, 0, 2'd0, 32'h80000000, 0, 0, 32'hC0000000, 1);
    add(0, -1, 2'd3, 32'h80000000, 0, 0, 32'h38000000, 1);
    run_stream(1'b0, 50);
    lat_chk = 1'b0;

    // Rounding
    add(0, 0, 2'd0, 32'h80000008, 0, 0, 32'h40000000, 1);
    add(0, 0, 2'd0, 32'h80000018, 0, 0, RNE ? 32'h40000002 : 32'h40000001, 1);
    // Saturation; k is 6 bits here, so 31 / -32 stand in for out-of-range regimes
    add(0, 30, 2'd0, 32'h80000000, 0, 0, 32'h7FFFFFFF, 1);
    add(0, 31, 2'd3, 32'hFFFFFFFF, 0, 0, 32'h7FFFFFFF, 1);
    add(0, -31, 2'd0, 32'h80000000, 0, 0, 32'h00000001, 1);
    add(0, -32, 2'd2, 32'hC0000000, 0, 0, 32'h00000001, 1);
    add(1, 31, 2'd1, 32'h80000000, 0, 0, 32'h80000001, 1);
    // Specials
    add(1, 5, 2'd2, 32'hDEADBEEF, 1, 0, 32'h80000000, 1);
    add(1, -3, 2'd1, 32'h9ABCDEF0, 0, 1, 32'h00000000, 1);
    add(0, 7, 2'd3, 32'hFFFFFFFF, 1, 1, 32'h80000000, 1);
    run_stream(1'b0, 50);

    // Backpressure: two stages fill, then input stalls and output holds
    out_ready = 1'b0;
    repeat (4) add_rand();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1);
      out_ready = 1'b0;
      tick();
    end
    check("bp_accepts", 32'(pend.size()), 32'd2);
    drive(1'b1);
    #1;
    check("bp_in_ready", 32'(in_ready), '0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_hold", out_posit, sb[0].val);
    tick();
    check("bp_hold2", out_posit, sb[0].val);
    run_stream(1'b0, 50);

    // Random traffic with random stalls
    for (int i = 0; i < 400; i++) add_rand();
    run_stream(1'b1, 6000);

    // Reset with both stages full
    out_ready = 1'b0;
    repeat (3) add_rand();
    drive(1'b1); tick();
    drive(1'b1); tick();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    check("midrst_out_valid", 32'(out_valid), '0);
    check("midrst_out_posit", out_posit, '0);
    rst = 1'b0;
    pend.delete();
    sb.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0);
      tick();
    end
    check("postrst_out_valid", 32'(out_valid), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
